// File: rtl/lcd_bus_scheduler.sv
// Two-requester round-robin write scheduler for an HD44780-style 8-bit LCD bus.
// Runs the power-on init sequence, then times setup / E pulse / hold / execution wait per write.
module lcd_bus_scheduler #(
  parameter int SETUP_CYC      = 50,
  parameter int PULSE_CYC      = 50,
  parameter int HOLD_CYC       = 50,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 100000,
  parameter int PWRUP_CYC      = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, SHORT_WAIT_CYC)),
                                max2(LONG_WAIT_CYC, PWRUP_CYC));
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT_LOAD, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_IDLE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_lim;
  logic            w_last;
  logic            w_long;
  logic [2:0]      r_idx;
  logic            r_ptr;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_init_done;
  logic            w_any;
  logic            w_sel;
  logic [7:0]      w_init_byte;

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h06;
      2'd2:    w_init_byte = 8'h0C;
      default: w_init_byte = 8'h01;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_lim      = '0;
    w_any      = 1'b0;
    w_sel      = r_ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // Clear and home need the long execution time; everything else is short.
    w_long     = !r_rs && (r_data == 8'h01 || r_data == 8'h02);

    case (r_state)
      S_PWRUP: w_lim = CW'(PWRUP_CYC - 1);
      S_SETUP: w_lim = CW'(SETUP_CYC - 1);
      S_PULSE: w_lim = CW'(PULSE_CYC - 1);
      S_HOLD:  w_lim = CW'(HOLD_CYC - 1);
      S_WAIT:  w_lim = w_long ? CW'(LONG_WAIT_CYC - 1) : CW'(SHORT_WAIT_CYC - 1);
      default: w_lim = '0;
    endcase
    w_last = (r_cnt == w_lim);

    if (r_state == S_IDLE && r_init_done) begin
      if (req0_valid && req1_valid) begin
        w_any = 1'b1;
        w_sel = r_ptr;
      end else if (req0_valid) begin
        w_any = 1'b1;
        w_sel = 1'b0;
      end else if (req1_valid) begin
        w_any = 1'b1;
        w_sel = 1'b1;
      end
    end
    req0_ready = w_any && !w_sel;
    req1_ready = w_any && w_sel;

    case (r_state)
      S_PWRUP:     if (w_last) w_next = S_INIT_LOAD;
      S_INIT_LOAD: w_next = S_SETUP;
      S_SETUP:     if (w_last) w_next = S_PULSE;
      S_PULSE:     if (w_last) w_next = S_HOLD;
      S_HOLD:      if (w_last) w_next = S_WAIT;
      S_WAIT:      if (w_last) w_next = (r_idx < 3'd4) ? S_INIT_LOAD : S_IDLE;
      S_IDLE:      if (w_any) w_next = S_SETUP;
      default:     w_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_ptr       <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state == S_INIT_LOAD) begin
        r_rs   <= 1'b0;
        r_data <= w_init_byte;
        r_idx  <= r_idx + 3'd1;
      end
      if (w_any) begin
        r_rs   <= w_sel ? req1_rs : req0_rs;
        r_data <= w_sel ? req1_data : req0_data;
        // Pointer only moves on contention so a lone requester never loses priority.
        if (req0_valid && req1_valid) r_ptr <= ~w_sel;
      end
      if (r_state == S_WAIT && w_next == S_IDLE) r_init_done <= 1'b1;
    end
  end

  assign init_done = r_init_done;
  assign busy      = (r_state != S_IDLE);
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = (r_state == S_PULSE);
  assign lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: timeline model of scheduled writes checked every cycle,
// plus literal pins on init timing, accept spacing and grant order.
module tb_lcd_bus_scheduler;
  localparam int S = 2, P = 3, H = 2, SW = 5, LW = 20, PW = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready, init_done, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  lcd_bus_scheduler #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW), .PWRUP_CYC(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // cyc = cycles since the last clock edge that sampled reset low
  always @(posedge clk) begin
    if (!reset) begin
      cyc   <= 0;
      armed <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  // Model: list of writes (bus-valid cycle t0, rs, data) and the first cycle the bus is free.
  int         wt0[$];
  logic       wrs[$];
  logic [7:0] wdat[$];
  int         free_at, init_end;
  bit         mptr;

  // Monitors
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         acc_cyc[$];
  int         acc_id[$];
  int         idone_cyc = -1;
  bit         prev_e = 1'b0;

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? LW : SW;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    logic [7:0] ib[4];
    int t, e;
    ib = '{8'h38, 8'h06, 8'h0C, 8'h01};
    wt0.delete(); wrs.delete(); wdat.delete();
    t = PW + 1;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      wt0.push_back(t); wrs.push_back(1'b0); wdat.push_back(ib[i]);
      e = t + S + P + H + wait_of(1'b0, ib[i]);
      t = e + 1;
    end
    init_end = e;
    free_at  = e;
    mptr     = 1'b0;
    idone_cyc = -1;
  endtask

  always @(negedge clk) begin : cmp
    int c;
    logic er, ee, g0, g1, idle;
    logic [7:0] ed;
    if (armed) begin
      c = cyc;
      if (c == 0) model_reset();
      er = 1'b0; ed = 8'h00; ee = 1'b0;
      for (int i = 0; i < wt0.size(); i++) begin
        if (wt0[i] <= c) begin er = wrs[i]; ed = wdat[i]; end
        if (c >= wt0[i] + S && c < wt0[i] + S + P) ee = 1'b1;
      end
      idle = (c >= free_at);
      g0 = 1'b0; g1 = 1'b0;
      if (idle) begin
        if (req0_valid && req1_valid) begin g0 = !mptr; g1 = mptr; end
        else begin g0 = req0_valid; g1 = req1_valid; end
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("lcd_e", lcd_e, ee);
      chk("lcd_rs", lcd_rs, er);
      chk("lcd_data", lcd_data, ed);
      chk("lcd_rw", lcd_rw, 0);
      chk("busy", busy, !idle);
      chk("init_done", init_done, c >= init_end);
      if (g0 || g1) begin
        wt0.push_back(c + 1);
        wrs.push_back(g1 ? req1_rs : req0_rs);
        wdat.push_back(g1 ? req1_data : req0_data);
        free_at = c + 1 + S + P + H + wait_of(g1 ? req1_rs : req0_rs, g1 ? req1_data : req0_data);
        if (req0_valid && req1_valid) mptr = g0;
      end
      if (lcd_e && !prev_e) begin rise_cyc.push_back(c); rise_dat.push_back(lcd_data); end
      prev_e = lcd_e;
      if (req0_ready && req0_valid) begin acc_cyc.push_back(c); acc_id.push_back(0); end
      if (req1_ready && req1_valid) begin acc_cyc.push_back(c); acc_id.push_back(1); end
      if (init_done && idone_cyc < 0) idone_cyc = c;
    end
  end

  task automatic clear_mon();
    rise_cyc.delete(); rise_dat.delete(); acc_cyc.delete(); acc_id.delete();
  endtask

  task automatic wait_acc(input int n, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (acc_cyc.size() >= n) return;
    end
    vec++; mis++;
    $display("FAIL %s timeout got=%0d accepts want=%0d", name, acc_cyc.size(), n);
  endtask

  initial begin
    int exp_rise[4];
    logic [7:0] exp_dat[4];
    exp_rise = '{13, 26, 39, 52};
    exp_dat  = '{8'h38, 8'h06, 8'h0C, 8'h01};

    // Power-on init
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    clear_mon();
    repeat (82) @(posedge clk);
    #1;
    chk("init_rises", rise_cyc.size(), 4);
    if (rise_cyc.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("init_rise_cyc", rise_cyc[i], exp_rise[i]);
        chk("init_rise_dat", rise_dat[i], exp_dat[i]);
      end
    chk("init_done_cyc", idone_cyc, 77);

    // Single data write from requester 0
    clear_mon();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    wait_acc(1, 30, "single");
    req0_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    if (acc_cyc.size() >= 1 && rise_cyc.size() >= 1) begin
      chk("single_id", acc_id[0], 0);
      chk("single_e_delay", rise_cyc[0] - acc_cyc[0], 3);
    end

    // Contention: strict alternation
    clear_mon();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h31;
    wait_acc(4, 80, "rr");
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (acc_cyc.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("rr_id", acc_id[i], i % 2);
        if (i > 0) chk("rr_gap", acc_cyc[i] - acc_cyc[i-1], 13);
      end
    repeat (15) @(posedge clk);
    #1;

    // Long wait after clear, short after set-DDRAM
    clear_mon();
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
    wait_acc(1, 40, "clr");
    req1_data = 8'h80;
    wait_acc(2, 60, "ddram");
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h42;
    wait_acc(3, 40, "after_ddram");
    req0_valid = 1'b0;
    if (acc_cyc.size() >= 3) begin
      chk("long_gap", acc_cyc[1] - acc_cyc[0], 28);
      chk("short_gap", acc_cyc[2] - acc_cyc[1], 13);
    end
    repeat (15) @(posedge clk);

    // Reset mid-pulse of the second init write, requests held through re-init
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    clear_mon();
    for (int i = 0; i < 60 && rise_cyc.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("second_rise_seen", rise_cyc.size(), 2);
    chk("e_before_reset", lcd_e, 1);
    reset = 1'b0;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
    @(posedge clk); #1;
    chk("e_after_reset", lcd_e, 0);
    chk("bus_after_reset", lcd_data, 0);
    reset = 1'b1;
    clear_mon();
    wait_acc(1, 120, "held_req");
    req0_valid = 1'b0;
    if (acc_cyc.size() >= 1 && rise_cyc.size() >= 1) begin
      chk("held_acc_cyc", acc_cyc[0], 77);
      chk("reinit_first_rise", rise_cyc[0], 13);
      chk("reinit_first_dat", rise_dat[0], 8'h38);
    end
    repeat (20) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
